// File: rtl/fp16_to_fp32_widen.sv
// Widens a packed pair of FP16 values (or passes an FP32 word through) into FP32 results, one lane at a time.
// Build option: define FP16TOFP32_SUBNORM_EN to normalize FP16 subnormals instead of flushing them to signed zero.
module fp16_to_fp32_widen #(
  parameter int PARM_XLEN = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PARM_XLEN-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PARM_XLEN-1:0] out_data,
  output logic                 NV_out
);

  // state | meaning
  // IDLE  | waiting for an input word
  // CONV  | decode current lane (or pass FP32 through)
  // NORM  | shift a subnormal mantissa until its leading one reaches bit 10
  // OUT   | result held until out_ready
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
`ifdef FP16TOFP32_SUBNORM_EN
    NORM = 2'd2,
`endif
    OUT  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic                 lane_q, lane_d;
  logic                 mode_q, mode_d;
  logic [PARM_XLEN-1:0] word_q, word_d;
  logic [PARM_XLEN-1:0] out_data_q, out_data_d;
  logic                 nv_q, nv_d;

  logic [15:0] half;
  logic        s;
  logic [4:0]  e;
  logic [9:0]  f;

  assign half = lane_q ? word_q[31:16] : word_q[15:0];
  assign s    = half[15];
  assign e    = half[14:10];
  assign f    = half[9:0];

`ifdef FP16TOFP32_SUBNORM_EN
  logic [10:0] m_q, m_d;
  logic [7:0]  x_q, x_d;
  logic [10:0] m_sh;
  logic [7:0]  x_dec;

  assign m_sh  = m_q << 1;
  assign x_dec = x_q - 8'd1;
`endif

  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    mode_d     = mode_q;
    word_d     = word_q;
    out_data_d = out_data_q;
    nv_d       = nv_q;
`ifdef FP16TOFP32_SUBNORM_EN
    m_d        = m_q;
    x_d        = x_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          word_d  = in_data;
          mode_d  = mode;
          lane_d  = 1'b0;
          state_d = CONV;
        end
      end
      CONV: begin
        state_d = OUT;
        nv_d    = 1'b0;
        if (!mode_q) begin
          out_data_d = word_q;
        end else if (e == 5'd31) begin
          if (f == 10'd0) begin
            out_data_d = {s, 8'hFF, 23'b0};
          end else begin
            out_data_d = {s, 8'hFF, 1'b1, f[8:0], 13'b0};
            nv_d       = ~f[9];
          end
        end else if (e != 5'd0) begin
          out_data_d = {s, {3'b000, e} + 8'd112, f, 13'b0};
        end else if (f == 10'd0) begin
          out_data_d = {s, 31'b0};
        end else begin
`ifdef FP16TOFP32_SUBNORM_EN
          m_d     = {1'b0, f};
          x_d     = 8'd113;
          state_d = NORM;
`else
          out_data_d = {s, 31'b0};
`endif
        end
      end
`ifdef FP16TOFP32_SUBNORM_EN
      NORM: begin
        m_d = m_sh;
        x_d = x_dec;
        if (m_sh[10]) begin
          out_data_d = {s, x_dec, m_sh[9:0], 13'b0};
          state_d    = OUT;
        end
      end
`endif
      OUT: begin
        if (out_ready) begin
          if (mode_q && !lane_q) begin
            lane_d  = 1'b1;
            state_d = CONV;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      lane_q     <= 1'b0;
      mode_q     <= 1'b0;
      word_q     <= '0;
      out_data_q <= '0;
      nv_q       <= 1'b0;
`ifdef FP16TOFP32_SUBNORM_EN
      m_q        <= '0;
      x_q        <= '0;
`endif
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      mode_q     <= mode_d;
      word_q     <= word_d;
      out_data_q <= out_data_d;
      nv_q       <= nv_d;
`ifdef FP16TOFP32_SUBNORM_EN
      m_q        <= m_d;
      x_q        <= x_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  assign out_data  = out_data_q;
  assign NV_out    = nv_q;

endmodule

// File: doc/fp16_to_fp32_widen.md
FP16_TO_FP32_WIDEN -- requirements
Module: fp16_to_fp32_widen

Interface
REQ-001 SHALL have parameter PARM_XLEN, default 32, the data word width; only 32 is supported.
REQ-002 SHALL have port clk, input, 1 bit: single clock, all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port mode, input, 1 bit: 1 = packed FP16 pair (lane0 = in_data[15:0], lane1 = in_data[31:16]); 0 = FP32 passthrough. Sampled with in_data.
REQ-005 SHALL have port in_valid, input, 1 bit: input word offered.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts input.
REQ-007 SHALL have port in_data, input, PARM_XLEN bits: input word.
REQ-008 SHALL have port out_valid, output, 1 bit: result available.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer accepts result.
REQ-010 SHALL have port out_data, output, PARM_XLEN bits: FP32 result.
REQ-011 SHALL have port NV_out, output, 1 bit: invalid flag, qualified by out_valid.

Function
REQ-012 SHALL implement FSM states IDLE, CONV, NORM, OUT; in_ready = (state==IDLE).
REQ-013 IDLE: on in_valid&&in_ready, SHALL latch in_data and mode, set lane=0, go to CONV.
REQ-014 CONV with latched mode=0: SHALL load out_data=latched word and NV_out=0, then go to OUT.
REQ-015 CONV with mode=1: SHALL decode the current lane (sign s, exp e[4:0], frac f[9:0]).
REQ-016 Normal case (0<e<31): SHALL produce {s, e+8'd112, f, 13'b0}, then go to OUT.
REQ-017 Zero case (e=0, f=0): SHALL produce {s, 31'b0}.
REQ-018 Infinity case (e=31, f=0): SHALL produce {s, 8'hFF, 23'b0}.
REQ-019 NaN case (e=31, f!=0): SHALL produce {s, 8'hFF, 1'b1, f[8:0], 13'b0}, with NV_out=1 iff f[9]=0 (signalling NaN).
REQ-020 Subnormal case (e=0, f!=0): SHALL go to NORM with mantissa m={1'b0,f} and biased exponent x=113.
REQ-021 NORM: each cycle SHALL shift m left one bit and decrement x; when m[10]=1 it SHALL produce {s, x, m[9:0], 13'b0} and go to OUT.
REQ-022 For frac MSB index p, the subnormal path SHALL take exactly 10-p NORM cycles and end with x = 103+p.
REQ-023 OUT: SHALL hold out_valid=1 with out_data and NV_out stable until out_ready.
REQ-024 On an OUT handshake with mode=1 and lane=0, SHALL set lane=1 and go to CONV; otherwise SHALL go to IDLE.
REQ-025 Latency: a normal lane's out_valid SHALL rise 2 cycles after the input handshake; a subnormal lane adds 10-p cycles; lane1 CONV starts the cycle after the lane0 handshake.
REQ-026 SHALL NOT accept new input until the last lane of the current word is handshaken; there is no bypass.

Reset
REQ-027 On rst, SHALL force state=IDLE, lane=0, out_valid=0, out_data=0, NV_out=0, so in_ready=1 in the cycle after reset.
REQ-028 rst asserted in any state, including mid-NORM or mid-OUT, SHALL discard the word in flight, with no output emitted for it.

Configuration
REQ-029 Macro FP16TOFP32_SUBNORM_EN defined: subnormals SHALL be normalized per REQ-020..REQ-022.
REQ-030 Macro FP16TOFP32_SUBNORM_EN undefined: the NORM state and shifter SHALL be omitted, and subnormals SHALL flush to {s, 31'b0} from CONV with NV_out=0.

Verification
REQ-031 Scenario: mode=1, in_data=32'hC0003C00, out_ready=1 -> 32'h3F800000 then 32'hC0000000; NV_out=0.
REQ-032 Scenario: mode=1, lane0=16'h7BFF -> 32'h477FE000, out_valid asserted 2 cycles after the handshake.
REQ-033 Scenario: lane0=16'h0001 with the macro defined -> 32'h33800000 after 10 NORM cycles; macro undefined -> 32'h00000000.
REQ-034 Scenario: lane0=16'h7C01 -> 32'h7FC02000 with NV_out=1; lane1=16'h7E00 -> 32'h7FC00000 with NV_out=0.
REQ-035 Scenario: mode=0, in_data=32'h12345678, out_ready held low 5 cycles -> out_data stable at 32'h12345678, in_ready=0 throughout, exactly one output.
REQ-036 Scenario: rst pulsed during NORM of 16'h0001 -> out_valid=0 and in_ready=1 in the next cycle; the next word converts correctly.
